// File: rtl/conv1_f.sv
// 5x5 valid convolution of a 32x32 binary32 image on one shared FP32 multiply-add datapath.
// Each output takes 25 cycles, one filter tap per clock. Results land in a registered 28x28 map.
module conv1_f #(
  parameter int IMG_N = 32,
  parameter int FLT_N = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] Image  [IMG_N][IMG_N],
  input  logic [DW-1:0] Filter [FLT_N][FLT_N],
  output logic [DW-1:0] Out    [IMG_N-FLT_N+1][IMG_N-FLT_N+1],
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_dbg
);
  localparam int OUT_N = IMG_N - FLT_N + 1;
  localparam int IW    = $clog2(IMG_N);
  localparam int FW    = $clog2(FLT_N);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] i, j;
  logic [FW-1:0] r, c;
  logic [DW-1:0] acc, pix, wgt, mac;
  logic          last_tap, last_out;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int k = 0; k < 27; k++) if (v[k]) n = 5'(26 - k);
    return n;
  endfunction

  // Subnormal operands count as zero; results below the normal range flush to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, s, up;
    logic [47:0] p;
    logic [23:0] m;
    logic [24:0] mr;
    logic signed [9:0] e;
    sgn    = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
    if (a_inf || b_inf) return {sgn, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {sgn, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; s = |p[22:0]; e = e + 10'sd1;
    end else begin
      m = p[46:23]; g = p[22]; s = |p[21:0];
    end
    up = g & (s | m[0]);
    mr = {1'b0, m} + 25'(up);
    if (mr[24]) begin
      mr = mr >> 1; e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
    if (e <= 10'sd0) return {sgn, 31'd0};
    return {sgn, e[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up;
    logic [31:0] big, sml;
    logic [7:0]  d;
    logic [5:0]  dd;
    logic [49:0] sh;
    logic [26:0] big27, sml27, diff, m;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [24:0] mr;
    logic signed [9:0] e;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return QNAN;
    if (a_inf) return {a[31], 8'hFF, 23'd0};
    if (b_inf) return {b[31], 8'hFF, 23'd0};
    if (a_zero && b_zero) return 32'd0;
    if (a_zero) return b;
    if (b_zero) return a;
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else                    begin big = b; sml = a; end
    d     = big[30:23] - sml[30:23];
    dd    = (d > 8'd49) ? 6'd49 : d[5:0];
    big27 = {1'b1, big[22:0], 3'b000};
    sh    = {1'b1, sml[22:0], 26'd0} >> dd;
    sml27 = {sh[49:24], |sh[23:0]};
    e     = $signed({2'b00, big[30:23]});
    if (big[31] == sml[31]) begin
      sum = {1'b0, big27} + {1'b0, sml27};
      if (sum[27]) begin
        m = {sum[27:2], sum[1] | sum[0]}; e = e + 10'sd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      diff = big27 - sml27;
      if (diff == 27'd0) return 32'd0;
      lz = lzc27(diff);
      m  = diff << lz;
      e  = e - $signed({5'b00000, lz});
    end
    up = m[2] & (m[1] | m[0] | m[3]);
    mr = {1'b0, m[26:3]} + 25'(up);
    if (mr[24]) begin
      mr = mr >> 1; e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {big[31], 8'hFF, 23'd0};
    if (e <= 10'sd0) return {big[31], 31'd0};
    return {big[31], e[7:0], mr[22:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last_tap  = (r == FW'(FLT_N - 1)) && (c == FW'(FLT_N - 1));
    last_out  = (i == IW'(OUT_N - 1)) && (j == IW'(OUT_N - 1));
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_tap && last_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Image and Filter are read live; the caller keeps them stable for the whole run.
  always_comb begin
    pix = Image[i + IW'(r)][j + IW'(c)];
    wgt = Filter[r][c];
    mac = fp_add(acc, fp_mul(pix, wgt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i   <= '0;
      j   <= '0;
      r   <= '0;
      c   <= '0;
      acc <= '0;
      for (int y = 0; y < OUT_N; y++)
        for (int x = 0; x < OUT_N; x++) Out[y][x] <= '0;
    end else if (state == IDLE && start) begin
      i   <= '0;
      j   <= '0;
      r   <= '0;
      c   <= '0;
      acc <= '0;
    end else if (state == RUN) begin
      if (last_tap) begin
        Out[i][j] <= mac;
        acc       <= '0;
        r         <= '0;
        c         <= '0;
        if (j == IW'(OUT_N - 1)) begin
          j <= '0;
          i <= last_out ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end else begin
        acc <= mac;
        if (c == FW'(FLT_N - 1)) begin
          c <= '0;
          r <= r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;
endmodule

// File: tb/tb_conv1_f.sv
// Bench for conv1_f: integer-exact stimulus, an expected-value queue filled when each run is
// launched and drained against the output map once done pulses; also timing of busy/done.
module tb_conv1_f;
  localparam int IMG_N   = 32;
  localparam int FLT_N   = 5;
  localparam int OUT_N   = 28;
  localparam int DW      = 32;
  localparam int RUN_CYC = OUT_N * OUT_N * FLT_N * FLT_N;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [DW-1:0] image   [IMG_N][IMG_N];
  logic [DW-1:0] filter  [FLT_N][FLT_N];
  logic [DW-1:0] out_map [OUT_N][OUT_N];
  logic          busy, done;
  logic [1:0]    state_dbg;

  int            img_i [IMG_N][IMG_N];
  int            flt_i [FLT_N][FLT_N];
  logic [DW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            done_cnt = 0;

  conv1_f dut (
    .clk(clk), .rst(rst), .start(start),
    .Image(image), .Filter(filter), .Out(out_map),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] int_to_fp(input int v);
    int          a, msb;
    logic [31:0] ua;
    if (v == 0) return 32'h0;
    a   = (v < 0) ? -v : v;
    msb = 0;
    for (int k = 0; k < 24; k++) if (a[k]) msb = k;
    ua = 32'(a) << (23 - msb);
    return {(v < 0), 8'(127 + msb), ua[22:0]};
  endfunction

  task automatic apply_ints();
    for (int y = 0; y < IMG_N; y++)
      for (int x = 0; x < IMG_N; x++) image[y][x] = int_to_fp(img_i[y][x]);
    for (int y = 0; y < FLT_N; y++)
      for (int x = 0; x < FLT_N; x++) filter[y][x] = int_to_fp(flt_i[y][x]);
  endtask

  // All partial sums stay small integers, so the exact integer result is the float result.
  task automatic push_int_model();
    int s;
    for (int y = 0; y < OUT_N; y++)
      for (int x = 0; x < OUT_N; x++) begin
        s = 0;
        for (int rr = 0; rr < FLT_N; rr++)
          for (int cc = 0; cc < FLT_N; cc++) s += img_i[y+rr][x+cc] * flt_i[rr][cc];
        exp_q.push_back(int_to_fp(s));
      end
  endtask

  task automatic push_const(input logic [DW-1:0] v);
    for (int k = 0; k < OUT_N * OUT_N; k++) exp_q.push_back(v);
  endtask

  task automatic drain(input string tag);
    logic [DW-1:0] want;
    for (int y = 0; y < OUT_N; y++)
      for (int x = 0; x < OUT_N; x++) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check($sformatf("%s_out[%0d][%0d]", tag, y, x), out_map[y][x], want);
      end
  endtask

  task automatic run_to_done(input string tag, input bit poke);
    int cyc, busy_cnt;
    bit seen;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc <= RUN_CYC + 50) begin
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin
        start = poke && (cyc == 100);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(RUN_CYC + 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(RUN_CYC));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0;
    for (int y = 0; y < IMG_N; y++) for (int x = 0; x < IMG_N; x++) img_i[y][x] = 0;
    for (int y = 0; y < FLT_N; y++) for (int x = 0; x < FLT_N; x++) flt_i[y][x] = 0;
    apply_ints();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    push_const(32'h0);
    drain("reset");

    // All ones: every output is 25.0.
    for (int y = 0; y < IMG_N; y++) for (int x = 0; x < IMG_N; x++) img_i[y][x] = 1;
    for (int y = 0; y < FLT_N; y++) for (int x = 0; x < FLT_N; x++) flt_i[y][x] = 1;
    apply_ints();
    push_const(32'h41C80000);
    run_to_done("ones", 1'b0);
    drain("ones");

    // Centre-tap filter on a ramp image, interrupted by reset, then rerun to completion.
    for (int y = 0; y < IMG_N; y++) for (int x = 0; x < IMG_N; x++) img_i[y][x] = y * 32 + x;
    for (int y = 0; y < FLT_N; y++) for (int x = 0; x < FLT_N; x++) flt_i[y][x] = 0;
    flt_i[2][2] = 1;
    apply_ints();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4999) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    push_const(32'h0);
    drain("midrst");
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'(d0));
    for (int y = 0; y < OUT_N; y++)
      for (int x = 0; x < OUT_N; x++) exp_q.push_back(image[y+2][x+2]);
    run_to_done("ident", 1'b0);
    drain("ident");

    // Hand-checked corner (1865.0) with random signed small integers elsewhere.
    for (int y = 0; y < IMG_N; y++)
      for (int x = 0; x < IMG_N; x++) img_i[y][x] = int'($urandom_range(0, 8)) - 4;
    for (int x = 0; x < IMG_N; x++) begin img_i[0][x] = 1; img_i[1][x] = 1; end
    for (int x = 0; x < 5; x++) begin
      img_i[2][x] = (x == 4) ? 15 : x + 1;
      img_i[3][x] = 5 + x;
      img_i[4][x] = 10 + x;
      flt_i[0][x] = (x == 4) ? 15 : x + 1;
      flt_i[1][x] = 5 + x;
      flt_i[2][x] = 10 + x;
      flt_i[3][x] = (x % 2 == 0) ? 15 : 16;
      flt_i[4][x] = (x % 2 == 0) ? 16 : 15;
    end
    apply_ints();
    push_int_model();
    run_to_done("mixed", 1'b0);
    check("mixed_corner_1865", out_map[0][0], 32'h44E92000);
    drain("mixed");

    // NaN weight poisons every output; a start pulse mid-run must be ignored.
    for (int y = 0; y < IMG_N; y++) for (int x = 0; x < IMG_N; x++) img_i[y][x] = 1;
    for (int y = 0; y < FLT_N; y++) for (int x = 0; x < FLT_N; x++) flt_i[y][x] = 1;
    apply_ints();
    filter[0][0] = 32'h7FC00001;
    push_const(32'h7FC00000);
    run_to_done("nan", 1'b1);
    drain("nan");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
